// File: rtl/avalon_ctrl_master.sv
// avalon_ctrl_master: single-outstanding Avalon-MM master for register access.
// A requester holds wr_rq or rd_rq until action_done pulses. Every output is a flop.
// Strobes and address change on the edge that enters or leaves WRITE/READ.
// action_done and rd_valid follow the DONE state by one cycle.
// Optional feature: define AVM_TIMEOUT_EN to build the TIMEOUT_CYCLES watchdog.
// Without that macro the master waits on the slave indefinitely and err stays 0.
module avalon_ctrl_master #(
    parameter int          BYTE_ADDR      = 1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_rq,
    input  logic        rd_rq,
    input  logic [31:0] wr_adr,
    input  logic [31:0] rd_adr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        action_done,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RDV, DONE, GAP} state_t;

    state_t      state, state_d;
    logic [31:0] avm_address_d, avm_writedata_d, rd_data_d;
    logic        avm_write_d, avm_read_d, rd_valid_d, action_done_d;
    logic        is_read, is_read_d;

`ifdef AVM_TIMEOUT_EN
    logic [15:0] wd_cnt, wd_cnt_d;
    logic        err_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    // Register offsets become byte addresses when BYTE_ADDR is set.
    function automatic logic [31:0] map_addr(input logic [31:0] adr);
        return (BYTE_ADDR != 0) ? {adr[29:0], 2'b00} : adr;
    endfunction

    // Next state and next value of every registered output.
    always_comb begin
        // NOTE: every variable gets a default here, so no path can leave one unassigned and infer a latch.
        state_d         = state;
        avm_address_d   = avm_address;
        avm_writedata_d = avm_writedata;
        rd_data_d       = rd_data;
        avm_write_d     = 1'b0;
        avm_read_d      = 1'b0;
        rd_valid_d      = 1'b0;
        action_done_d   = 1'b0;
        is_read_d       = is_read;
`ifdef AVM_TIMEOUT_EN
        wd_cnt_d        = 16'd0;
        err_d           = err;
`endif
        case (state)
            IDLE: begin
                if (wr_rq) begin
                    avm_address_d   = map_addr(wr_adr);
                    avm_writedata_d = wr_data;
                    avm_write_d     = 1'b1;
                    is_read_d       = 1'b0;
                    state_d         = WRITE;
                end else if (rd_rq) begin
                    avm_address_d = map_addr(rd_adr);
                    avm_read_d    = 1'b1;
                    is_read_d     = 1'b1;
                    state_d       = READ;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) state_d = DONE;
                else                  avm_write_d = 1'b1;
            end
            READ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        rd_data_d = avm_readdata;
                        state_d   = DONE;
                    end else begin
                        state_d = WAIT_RDV;
                    end
                end else begin
                    avm_read_d = 1'b1;
                end
            end
            WAIT_RDV: begin
                if (avm_readdatavalid) begin
                    rd_data_d = avm_readdata;
                    state_d   = DONE;
                end
            end
            DONE: begin
                action_done_d = 1'b1;
                rd_valid_d    = is_read;
                state_d       = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef AVM_TIMEOUT_EN
        // The watchdog counts every busy cycle and aborts only if no progress was made this cycle.
        if (state == WRITE || state == READ || state == WAIT_RDV) begin
            wd_cnt_d = wd_cnt + 16'd1;
            if (state_d == state && ({1'b0, wd_cnt} + 17'd1 >= {1'b0, TIMEOUT_CYCLES})) begin
                avm_write_d = 1'b0;
                avm_read_d  = 1'b0;
                rd_data_d   = 32'hDEAD_BEEF;
                err_d       = 1'b1;
                state_d     = DONE;
            end
        end
`endif
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            avm_address   <= 32'd0;
            avm_writedata <= 32'd0;
            rd_data       <= 32'd0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            rd_valid      <= 1'b0;
            action_done   <= 1'b0;
            is_read       <= 1'b0;
`ifdef AVM_TIMEOUT_EN
            wd_cnt        <= 16'd0;
            err           <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state         <= state_d;
            avm_address   <= avm_address_d;
            avm_writedata <= avm_writedata_d;
            rd_data       <= rd_data_d;
            avm_write     <= avm_write_d;
            avm_read      <= avm_read_d;
            rd_valid      <= rd_valid_d;
            action_done   <= action_done_d;
            is_read       <= is_read_d;
`ifdef AVM_TIMEOUT_EN
            wd_cnt        <= wd_cnt_d;
            err           <= err_d;
`endif
        end
    end

endmodule

// File: doc/avalon_ctrl_master.md
AVALON_CTRL_MASTER -- requirements
Module: avalon_ctrl_master

Interface
REQ-001 Parameter BYTE_ADDR, default 1: 1 = avm_address is the request address shifted left 2 (word offset to byte address); 0 = pass through unchanged.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in clk cycles, 16-bit.
REQ-003 Ports, one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low
- wr_rq  in  1  write request, held until action_done
- rd_rq  in  1  read request, held until action_done
- wr_adr  in  32  write register offset
- rd_adr  in  32  read register offset
- wr_data  in  32  write data
- rd_data  out  32  last read result
- rd_valid  out  1  one-cycle pulse, read result valid
- action_done  out  1  one-cycle pulse, transaction complete
- avm_address  out  32  Avalon-MM address
- avm_write  out  1  Avalon-MM write strobe
- avm_read  out  1  Avalon-MM read strobe
- avm_writedata  out  32  Avalon-MM write data
- avm_readdata  in  32  Avalon-MM read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid
- err  out  1  sticky timeout flag

Function
REQ-004 FSM states: IDLE, WRITE, READ, WAIT_RDV, DONE, GAP; all outputs registered.
REQ-005 IDLE: wr_rq=1 -> latch wr_adr/wr_data, go WRITE; else rd_rq=1 -> latch rd_adr, go READ; wr_rq and rd_rq both 1 -> write wins; the read is not serviced in that transaction.
REQ-006 Request sampling and strobe assertion: request sampled in cycle 0; avm_write or avm_read asserted from cycle 1.
REQ-007 WRITE: avm_write=1 with stable address/data while avm_waitrequest=1; first cycle with avm_waitrequest=0 -> DONE.
REQ-008 READ: avm_read=1 while avm_waitrequest=0 not yet seen.
- Acceptance with avm_readdatavalid=1 in the same cycle -> capture avm_readdata, go DONE.
- Acceptance without avm_readdatavalid -> go WAIT_RDV.
REQ-009 WAIT_RDV: strobes low; on avm_readdatavalid=1 capture avm_readdata into rd_data, go DONE.
REQ-010 DONE: action_done=1 for exactly one cycle; rd_valid=1 in the same cycle only for reads; next state GAP.
REQ-011 GAP: one cycle; requests ignored so the requester's still-high rq is not re-serviced; next state IDLE.
REQ-012 Minimum transaction with zero waitrequest is 4 cycles from request sample to action_done.
REQ-013 Strobes never both high; avm_write and avm_read are 0 in IDLE, WAIT_RDV, DONE and GAP.
REQ-014 rd_data holds its value until the next read capture; write transactions leave it unchanged.
REQ-015 Request dropped mid-transaction: the Avalon transaction still completes and action_done is still pulsed.

Reset
REQ-016 reset=0 asynchronously forces IDLE.
- rd_data, avm_address and avm_writedata are 0.
- rd_valid, action_done, avm_write, avm_read and err are 0.
- The watchdog counter is 0.
REQ-017 Reset asserted mid-transaction drops strobes immediately; no action_done is generated for the aborted transaction.

Configuration
REQ-018 Macro AVM_TIMEOUT_EN defined enables the watchdog.
- Counter clears in IDLE and increments in WRITE, READ and WAIT_RDV.
- On reaching TIMEOUT_CYCLES: strobes drop, rd_data=32'hDEAD_BEEF, err set (sticky until reset), go DONE (rd_valid pulses if the transaction was a read).
REQ-019 AVM_TIMEOUT_EN undefined: no counter logic; the FSM waits indefinitely; err is tied to 0.

Verification
REQ-020 Write, wr_adr=0x02, wr_data=0x0000AAAA, waitrequest=0 -> avm_address=0x08, one avm_write cycle, action_done in cycle 3, rd_valid=0.
REQ-021 Read, rd_adr=0x91, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with data 0x00000901 -> avm_read held 4 cycles, rd_data=0x00000901, rd_valid and action_done coincide.
REQ-022 wr_rq and rd_rq both 1 -> only avm_write issued; requester held high through DONE -> no second transaction until IDLE after GAP.
REQ-023 Reset pulled low during WRITE with waitrequest=1 -> avm_write=0 immediately, no action_done, clean write afterwards.
REQ-024 AVM_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck 1 on a read -> action_done at timeout, rd_data=0xDEADBEEF, err=1 until reset; without the macro -> no action_done, err=0.
